hex_display_bank: RTL and testbench
===================================

HEX_DISPLAY_BANK -- requirements
Module: hex_display_bank

Interface
REQ-001 Parameter DIGITS, default 8: number of seven-segment digits driven (1..8).
REQ-002 Parameter BLINK_DIV, default 25000000: clock cycles per blink half-period (>=1).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 value  input  4*DIGITS  hex nibbles; digit k = value[4k+3:4k], digit 0 least significant.
REQ-006 load  input  1  capture strobe; value sampled on a clk edge when load=1.
REQ-007 lz_blank  input  1  leading-zero blanking enable, sampled with value.
REQ-008 digit_en  input  DIGITS  per-digit enable, live (not captured); 0 forces digit off.
REQ-009 blink_mask  input  DIGITS  per-digit blink select, live.
REQ-010 display  output  7*DIGITS  active-low segments; digit k = display[7k+6:7k], bit0=a..bit6=g.
REQ-011 updated  output  1  one-cycle pulse when a captured value first reaches display.

Function
REQ-012 The block SHALL hold a shadow register (value, lz_blank) loaded only on load=1; otherwise the shadow is held.
REQ-013 The block SHALL register display; latency from load edge to new display SHALL be exactly 2 cycles (capture, then decode).
REQ-014 Decode codes (hex, active-low) SHALL be 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E; blank SHALL be 7F.
REQ-015 With captured lz_blank=1, each zero digit above the most significant non-zero digit SHALL be blank; digit 0 SHALL never be blanked by this rule.
REQ-016 digit_en[k]=0 SHALL force digit k to 7F on the next display update, regardless of value.
REQ-017 Blink: a counter SHALL count 0..BLINK_DIV-1 and toggle a phase bit on wrap; while phase=1, digits with blink_mask[k]=1 SHALL show 7F.
REQ-018 BLINK_DIV=1 SHALL toggle phase every cycle; counter width SHALL be clog2(BLINK_DIV) (min 1).
REQ-019 Back-to-back loads on consecutive cycles SHALL each appear on display for one cycle, in order, each with updated=1.
REQ-020 updated SHALL be load delayed by exactly 2 cycles; it SHALL not assert for digit_en/blink changes.
REQ-021 display SHALL re-evaluate every cycle from shadow, digit_en and blink phase (digit_en/blink effects 1-cycle latency).

Reset
REQ-022 rst_n=0 SHALL immediately force display to all 7F, updated=0, shadow value=0, shadow lz_blank=0, blink counter=0, phase=0.
REQ-023 A load in flight at reset SHALL be discarded; after release display SHALL show the shadow of 0 (digit 0 = 40, others 40) from the second clk edge.
REQ-024 Reset release SHALL be accepted on any cycle; first capture possible on the first edge with rst_n=1.

Configuration
REQ-025 Macro HEX_DISPLAY_BANK_BLINK_EN: when defined, REQ-017/018 blink logic SHALL be built.
REQ-026 When HEX_DISPLAY_BANK_BLINK_EN is undefined, no counter SHALL exist, blink_mask SHALL be ignored, phase SHALL be constant 0.

Verification
REQ-027 DIGITS=4: reset, release, load value=16'h12AF, lz_blank=0 -> display after 2 cycles = {79,24,08,0E} (digit3..0), updated pulse at cycle 2.
REQ-028 DIGITS=4: load value=16'h0030, lz_blank=1 -> digit3,2 = 7F, digit1 = 30, digit0 = 40; value=16'h0000 -> only digit0 = 40.
REQ-029 digit_en=4'b1011 after load 16'h8888 -> digit2 = 7F, others 00, no updated pulse on digit_en change.
REQ-030 Blink enabled, BLINK_DIV=3, blink_mask=4'b0001, value 16'h0005 -> digit0 alternates 12/7F every 3 cycles; other digits steady 40.
REQ-031 Loads on 3 consecutive cycles (1,2,3 in digit0) -> digit0 shows 79,24,30 on cycles 2,3,4, updated high 3 cycles.
REQ-032 Assert rst_n=0 one cycle after load of 16'hFFFF -> display 7F immediately, never shows 0E; after release digits show 40.

Source files
------------

// File: rtl/hex_display_bank.sv
// hex_display_bank: bank of DIGITS seven-segment hex digits.
// A (value, lz_blank) shadow register is captured on load. The display register
// is re-decoded every cycle from that shadow, the live per-digit enables and
// the blink phase.
// Optional blink logic is built only when HEX_DISPLAY_BANK_BLINK_EN is defined.
// Without it, phase is tied low and blink_mask has no effect.

// Per-digit decode: hex nibble to active-low segments, with blank overrides.
module hex_display_lane (
  input  logic [3:0] nib,
  input  logic       lz_kill,
  input  logic       en,
  input  logic       blink_off,
  output logic [6:0] seg
);
  logic [6:0] hex_seg;

  // hex nibble -> segments (bit0=a .. bit6=g, active-low)
  always_comb begin
    hex_seg = 7'h7F;
    case (nib)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      4'hF: hex_seg = 7'h0E;
      default: hex_seg = 7'h7F;
    endcase
  end

  // Any blanking reason wins over the decoded glyph.
  assign seg = (!en || lz_kill || blink_off) ? 7'h7F : hex_seg;
endmodule

module hex_display_bank #(
  parameter int DIGITS    = 8,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  lz_blank,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7*DIGITS-1:0]   display,
  output logic                  updated
);
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("hex_display_bank: DIGITS must be 1..8");
  end
  if (BLINK_DIV < 1) begin : g_bad_div
    $error("hex_display_bank: BLINK_DIV must be >= 1");
  end

  logic [DIGITS-1:0][3:0] sh_val;
  logic                   sh_lz;
  logic [DIGITS-1:0][6:0] disp_q;
  logic [DIGITS-1:0][6:0] disp_d;
  logic [DIGITS:0]        hi_zero;
  logic [DIGITS-1:0]      lz_kill;
  logic [DIGITS-1:0]      blink_off;
  logic [2:1]             vld_pipe;
  logic                   phase;

  // shadow capture; held whenever load is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_val <= '0;
      sh_lz  <= 1'b0;
    end else if (load) begin
      sh_val <= value;
      sh_lz  <= lz_blank;
    end
  end

`ifdef HEX_DISPLAY_BANK_BLINK_EN
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [CW-1:0] bcnt;

  // free-running half-period counter; phase flips on each wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == CW'(BLINK_DIV - 1)) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt  <= bcnt + 1'b1;
    end
  end
`else
  assign phase = 1'b0;
`endif

  // hi_zero[k]: digits k and everything above them are all zero
  always_comb begin
    hi_zero[DIGITS] = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--)
      hi_zero[k] = hi_zero[k+1] & (sh_val[k] == 4'h0);
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_lane
    // digit 0 always shows something, even for an all-zero value
    if (k == 0) begin : g_lsd
      assign lz_kill[k] = 1'b0;
    end else begin : g_upper
      assign lz_kill[k] = sh_lz & hi_zero[k];
    end
    assign blink_off[k] = phase & blink_mask[k];

    hex_display_lane u_lane (
      .nib       (sh_val[k]),
      .lz_kill   (lz_kill[k]),
      .en        (digit_en[k]),
      .blink_off (blink_off[k]),
      .seg       (disp_d[k])
    );
  end

  // display re-decoded every cycle; updated tracks load two edges later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q   <= {DIGITS{7'h7F}};
      vld_pipe <= '0;
    end else begin
      disp_q      <= disp_d;
      vld_pipe[1] <= load;
      vld_pipe[2] <= vld_pipe[1];
    end
  end

  assign display = disp_q;
  assign updated = vld_pipe[2];
endmodule

// File: tb/tb_hex_display_bank.sv
// Scoreboard bench for hex_display_bank, DIGITS=4, BLINK_DIV=3.
// Each load pushes its expected display; a negedge monitor pops on updated.
module tb_hex_display_bank;
  localparam int D = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4*D-1:0]  value;
  logic            load;
  logic            lz_blank;
  logic [D-1:0]    digit_en;
  logic [D-1:0]    blink_mask;
  logic [7*D-1:0]  display;
  logic            updated;

  int checks = 0;
  int errors = 0;
  logic [7*D-1:0] sb[$];

  hex_display_bank #(.DIGITS(D), .BLINK_DIV(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .lz_blank   (lz_blank),
    .digit_en   (digit_en),
    .blink_mask (blink_mask),
    .display    (display),
    .updated    (updated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7*D-1:0] act, input logic [7*D-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every updated pulse must match the oldest outstanding load
  always @(negedge clk) begin
    if (rst_n === 1'b1 && updated === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_updated: got updated=1 expected 0 (display %h)", display);
      end else begin
        chk("scoreboard", display, sb.pop_front());
      end
    end
  end

  task automatic do_load(input logic [15:0] v, input logic lz, input logic [7*D-1:0] exp);
    @(posedge clk); #1;
    value = v; lz_blank = lz; load = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_queue_empty", 28'(sb.size()), 28'd0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] s[12];
    logic [6:0] d0;
    bit ok;
    rst_n = 1'b1; value = '0; load = 1'b0; lz_blank = 1'b0;
    digit_en = '1; blink_mask = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_display", display, {4{7'h7F}});
    chk("reset_updated", 28'(updated), 28'd0);
    cycles(2);
    @(negedge clk) rst_n = 1'b1;
    cycles(3);
    chk("release_zero", display, {4{7'h40}});

    do_load(16'h12AF, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E});
    do_load(16'h0030, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40});
    do_load(16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    do_load(16'h0000, 1'b0, {4{7'h40}});
    do_load(16'h1000, 1'b1, {7'h79, 7'h40, 7'h40, 7'h40});
    do_load(16'hF00F, 1'b1, {7'h0E, 7'h40, 7'h40, 7'h0E});
    do_load(16'h0D0C, 1'b1, {7'h7F, 7'h21, 7'h40, 7'h46});
    do_load(16'h8888, 1'b0, {4{7'h00}});
    drain();

    // live enable: digit 2 goes dark, no updated pulse (monitor flags one)
    digit_en = 4'b1011;
    cycles(2);
    chk("digit_en_off", display, {7'h00, 7'h7F, 7'h00, 7'h00});
    digit_en = 4'b1111;
    cycles(2);
    chk("digit_en_on", display, {4{7'h00}});

    // back-to-back loads 1,2,3 -> three consecutive updated cycles
    @(posedge clk); #1;
    value = 16'h0001; lz_blank = 1'b0; load = 1'b1; sb.push_back({7'h40, 7'h40, 7'h40, 7'h79});
    @(posedge clk); #1;
    value = 16'h0002; sb.push_back({7'h40, 7'h40, 7'h40, 7'h24});
    @(posedge clk); #1;
    value = 16'h0003; sb.push_back({7'h40, 7'h40, 7'h40, 7'h30});
    @(posedge clk); #1;
    load = 1'b0;
    drain();

    // blink on digit 0
    do_load(16'h0005, 1'b0, {7'h40, 7'h40, 7'h40, 7'h12});
    drain();
    blink_mask = 4'b0001;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      s[i] = display[6:0];
      if (display[27:7] !== {3{7'h40}}) ok = 1'b0;
`ifdef HEX_DISPLAY_BANK_BLINK_EN
      if (s[i] !== 7'h12 && s[i] !== 7'h7F) ok = 1'b0;
`else
      if (s[i] !== 7'h12) ok = 1'b0;
`endif
    end
`ifdef HEX_DISPLAY_BANK_BLINK_EN
    for (int i = 0; i < 9; i++) if (s[i] === s[i+3]) ok = 1'b0;
    for (int i = 0; i < 6; i++) if (s[i] !== s[i+6]) ok = 1'b0;
`endif
    d0 = s[11];
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL blink_pattern: got digit0 sequence ending %h (%h %h %h %h %h %h) expected %s",
               d0, s[0], s[1], s[2], s[3], s[4], s[5],
`ifdef HEX_DISPLAY_BANK_BLINK_EN
               "12/7F alternating every 3 cycles"
`else
               "steady 12"
`endif
               );
    end
    blink_mask = 4'b0000;
    cycles(2);
    chk("blink_off_restore", display, {7'h40, 7'h40, 7'h40, 7'h12});

    // reset one cycle after a load of FFFF: in-flight load discarded
    @(posedge clk); #1;
    value = 16'hFFFF; lz_blank = 1'b0; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("reset_midload_display", display, {4{7'h7F}});
    chk("reset_midload_updated", 28'(updated), 28'd0);
    cycles(1);
    @(negedge clk) rst_n = 1'b1;
    cycles(1);
    chk("after_reset_first", 28'(display[6:0] == 7'h0E), 28'd0);
    cycles(2);
    chk("after_reset_zero", display, {4{7'h40}});

    // one more load after reset to confirm capture path still works
    do_load(16'hBEEF, 1'b0, {7'h03, 7'h06, 7'h06, 7'h0E});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
